// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RISC-V core: word RAM plus GPIO/timer MMIO block.
// Timer registers (COUNT/CMP/STATUS/CTRL) and timer_irq exist only when DMEM_TIMER_EN is defined.
`timescale 1ns/1ps

module dmem_responder #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  output logic [31:0]       read_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
`ifdef DMEM_TIMER_EN
  localparam logic [3:0] OFF_COUNT    = 4'h2;
  localparam logic [3:0] OFF_CMP      = 4'h3;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_CTRL     = 4'h5;
`endif

  logic          ram_hit;
  logic          mmio_hit;
  logic          mmio_we;
  logic [AW-1:0] ram_idx;
  logic [3:0]    offset;
  logic          unused_addr_lsbs;

  assign ram_hit          = addr < RAM_BYTES;
  assign mmio_hit         = addr[31:6] == MMIO_BASE[31:6];
  assign mmio_we          = mem_write & mmio_hit;
  assign ram_idx          = addr[AW+1:2];
  assign offset           = addr[5:2];
  assign unused_addr_lsbs = ^addr[1:0];

  logic [31:0] mem [RAM_WORDS];

  // RAM has no reset value; reset in the sensitivity list only blocks stores while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (mem_write && ram_hit) begin
      mem[ram_idx] <= write_data;
    end
  end

  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;

  // GPIO output register and two-flop input synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (mmio_we && offset == OFF_GPIO_OUT) begin
        gpio_out <= write_data[GPIO_W-1:0];
      end
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] count;
  logic [31:0] cmp;
  logic [31:0] count_next;
  logic        count_upd;
  logic        match;
  logic        match_set;
  logic        run;
  logic        irq_en;

  // A COUNT store overrides the increment; match only considers cycles where COUNT is updated
  always_comb begin
    count_next = count;
    count_upd  = 1'b0;
    if (mmio_we && offset == OFF_COUNT) begin
      count_next = write_data;
      count_upd  = 1'b1;
    end else if (run) begin
      count_next = count + 32'd1;
      count_upd  = 1'b1;
    end
  end

  assign match_set = count_upd && (count_next == cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      cmp    <= 32'hFFFF_FFFF;
      match  <= 1'b0;
      run    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      count <= count_next;
      if (mmio_we && offset == OFF_CMP) begin
        cmp <= write_data;
      end
      if (match_set) begin
        match <= 1'b1;
      end else if (mmio_we && offset == OFF_STATUS && write_data[0]) begin
        match <= 1'b0;
      end
      if (mmio_we && offset == OFF_CTRL) begin
        run    <= write_data[0];
        irq_en <= write_data[1];
      end
    end
  end

  assign timer_irq = match & irq_en;
`else
  assign timer_irq = 1'b0;
`endif

  // Zero-latency read mux; unmapped space and reserved offsets read 0
  always_comb begin
    read_data = '0;
    if (ram_hit) begin
      read_data = mem[ram_idx];
    end else if (mmio_hit) begin
      case (offset)
        OFF_GPIO_OUT: read_data = 32'(gpio_out);
        OFF_GPIO_IN:  read_data = 32'(sync2);
`ifdef DMEM_TIMER_EN
        OFF_COUNT:    read_data = count;
        OFF_CMP:      read_data = cmp;
        OFF_STATUS:   read_data = {31'b0, match};
        OFF_CTRL:     read_data = {30'b0, irq_en, run};
`endif
        default:      read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, timer/reset sequences,
// then randomized traffic against a behavioural memory-map model.
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam int unsigned RW = 256;
`ifdef DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam logic [31:0] CMP_RST = TIMER ? 32'hFFFF_FFFF : 32'h0;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  dmem_responder #(.RAM_WORDS(RW), .MMIO_BASE(MB), .GPIO_W(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .read_data(read_data), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr       = a;
    write_data = d;
    mem_write  = w;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drv(a, d, 1'b1);
    tick();
    mem_write = 1'b0;
  endtask

  task automatic check_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    drv(a, 32'h0, 1'b0);
    #1;
    check(nm, read_data, exp);
  endtask

  // Directed vectors: read_data / gpio_out expected before the row's edge
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    bit          chk;
    logic [31:0] rd;
    logic [7:0]  gp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input bit chk, input logic [31:0] rd, input logic [7:0] gp);
    vec_t v;
    v.a = a; v.d = d; v.w = w; v.chk = chk; v.rd = rd; v.gp = gp;
    vecs.push_back(v);
  endtask

  // Behavioural model of the memory map
  logic [31:0] m_ram [RW];
  bit          m_val [RW];
  logic [7:0]  m_gpio, m_h0, m_h1;
  logic [31:0] m_count, m_cmp;
  bit          m_match, m_run, m_ien;

  task automatic m_reset();
    m_gpio = 8'h0; m_h0 = 8'h0; m_h1 = 8'h0;
    m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
    m_match = 1'b0; m_run = 1'b0; m_ien = 1'b0;
  endtask

  function automatic logic [32:0] m_read(input logic [31:0] a);
    if (a < 32'(RW * 4)) return {m_val[a[9:2]], m_ram[a[9:2]]};
    if (a[31:6] == MB[31:6]) begin
      case (a[5:2])
        4'h0: return {1'b1, 24'h0, m_gpio};
        4'h1: return {1'b1, 24'h0, m_h1};
        4'h2: return {1'b1, TIMER ? m_count : 32'h0};
        4'h3: return {1'b1, TIMER ? m_cmp : 32'h0};
        4'h4: return {1'b1, 31'h0, TIMER & m_match};
        4'h5: return {1'b1, 30'h0, TIMER & m_ien, TIMER & m_run};
        default: return {1'b1, 32'h0};
      endcase
    end
    return {1'b1, 32'h0};
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [7:0] g);
    bit          mm;
    logic [3:0]  o;
    logic [31:0] nc;
    bit          upd;
    mm = (a[31:6] == MB[31:6]);
    o  = a[5:2];
    if (w && a < 32'(RW * 4)) begin
      m_ram[a[9:2]] = d;
      m_val[a[9:2]] = 1'b1;
    end
    if (w && mm && o == 4'h0) m_gpio = d[7:0];
    m_h1 = m_h0;
    m_h0 = g;
    if (TIMER) begin
      upd = 1'b0;
      nc  = m_count;
      if (w && mm && o == 4'h2) begin
        nc = d; upd = 1'b1;
      end else if (m_run) begin
        nc = m_count + 32'd1; upd = 1'b1;
      end
      if (w && mm && o == 4'h4 && d[0]) m_match = 1'b0;
      if (upd && nc == m_cmp) m_match = 1'b1;
      if (w && mm && o == 4'h3) m_cmp = d;
      if (w && mm && o == 4'h5) begin
        m_run = d[0];
        m_ien = d[1];
      end
      m_count = nc;
    end
  endtask

  logic [32:0] r;
  logic [31:0] ra, rd_v;
  logic        rw;
  int          kind;
  logic [3:0]  ro;

  initial begin
    reset = 1'b0; gpio_in = 8'h0;
    drv(32'h0, 32'h0, 1'b0);
    #12 reset = 1'b1;
    tick();
    check("rst_irq", 32'(timer_irq), 32'h0);

    add(MB + 32'h0C, 32'h0,          1'b0, 1'b1, CMP_RST,        8'h00);
    add(MB + 32'h10, 32'h0,          1'b0, 1'b1, 32'h0,          8'h00);
    add(MB + 32'h14, 32'h0,          1'b0, 1'b1, 32'h0,          8'h00);
    add(MB + 32'h08, 32'h0,          1'b0, 1'b1, 32'h0,          8'h00);
    add(MB + 32'h00, 32'h0,          1'b0, 1'b1, 32'h0,          8'h00);
    add(32'h10,      32'hDEAD_BEEF,  1'b1, 1'b0, 32'h0,          8'h00);
    add(32'h10,      32'h0,          1'b0, 1'b1, 32'hDEAD_BEEF,  8'h00);
    add(32'h13,      32'h0,          1'b0, 1'b1, 32'hDEAD_BEEF,  8'h00);
    add(32'h10,      32'hCAFE_F00D,  1'b1, 1'b1, 32'hDEAD_BEEF,  8'h00);
    add(32'h10,      32'h0,          1'b0, 1'b1, 32'hCAFE_F00D,  8'h00);
    add(32'h00,      32'h0000_0001,  1'b1, 1'b0, 32'h0,          8'h00);
    add(32'h20,      32'h0000_600D,  1'b1, 1'b0, 32'h0,          8'h00);
    add(32'h2000,    32'h1234_5678,  1'b1, 1'b1, 32'h0,          8'h00);
    add(32'h2000,    32'h0,          1'b0, 1'b1, 32'h0,          8'h00);
    add(32'h3FC,     32'h1122_3344,  1'b1, 1'b0, 32'h0,          8'h00);
    add(32'h3FC,     32'h0,          1'b0, 1'b1, 32'h1122_3344,  8'h00);
    add(32'h400,     32'h0000_0077,  1'b1, 1'b1, 32'h0,          8'h00);
    add(32'h00,      32'h0,          1'b0, 1'b1, 32'h0000_0001,  8'h00);
    add(MB + 32'h00, 32'h0000_005A,  1'b1, 1'b1, 32'h0,          8'h00);
    add(MB + 32'h00, 32'h0,          1'b0, 1'b1, 32'h0000_005A,  8'h5A);
    add(MB + 32'h00, 32'hFFFF_FF33,  1'b1, 1'b1, 32'h0000_005A,  8'h5A);
    add(MB + 32'h00, 32'h0,          1'b0, 1'b1, 32'h0000_0033,  8'h33);
    add(MB + 32'h04, 32'h0000_00FF,  1'b1, 1'b1, 32'h0,          8'h33);
    add(MB + 32'h04, 32'h0,          1'b0, 1'b1, 32'h0,          8'h33);
    add(MB + 32'h18, 32'hFFFF_FFFF,  1'b1, 1'b1, 32'h0,          8'h33);
    add(MB + 32'h18, 32'h0,          1'b0, 1'b1, 32'h0,          8'h33);
    add(MB + 32'h3C, 32'hFFFF_FFFF,  1'b1, 1'b1, 32'h0,          8'h33);
    add(MB + 32'h3C, 32'h0,          1'b0, 1'b1, 32'h0,          8'h33);

    foreach (vecs[i]) begin
      drv(vecs[i].a, vecs[i].d, vecs[i].w);
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), read_data, vecs[i].rd);
      check($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].gp));
      tick();
    end
    mem_write = 1'b0;

    // Synchroniser: new input visible only after the second edge
    gpio_in = 8'hA5;
    check_rd("gin_pre", MB + 32'h04, 32'h0);
    tick();
    check_rd("gin_edge1", MB + 32'h04, 32'h0);
    tick();
    check_rd("gin_edge2", MB + 32'h04, 32'h0000_00A5);

`ifdef DMEM_TIMER_EN
    wr(MB + 32'h0C, 32'd5);
    wr(MB + 32'h08, 32'd0);
    wr(MB + 32'h14, 32'h3);
    check_rd("cnt0", MB + 32'h08, 32'd0);
    repeat (4) tick();
    check_rd("cnt4", MB + 32'h08, 32'd4);
    check("irq_pre", 32'(timer_irq), 32'h0);
    tick();
    check_rd("cnt5", MB + 32'h08, 32'd5);
    check("irq_match", 32'(timer_irq), 32'h1);
    check_rd("status_set", MB + 32'h10, 32'h1);
    wr(MB + 32'h10, 32'h1);
    check("irq_w1c", 32'(timer_irq), 32'h0);
    check_rd("status_clr", MB + 32'h10, 32'h0);
    wr(MB + 32'h08, 32'd5);
    check("irq_cntwr", 32'(timer_irq), 32'h1);
    check_rd("cnt_exact", MB + 32'h08, 32'd5);
    wr(MB + 32'h10, 32'h1);
    check("irq_clr2", 32'(timer_irq), 32'h0);
    wr(MB + 32'h08, 32'hFFFF_FFFF);
    check_rd("cnt_max", MB + 32'h08, 32'hFFFF_FFFF);
    tick();
    check_rd("cnt_wrap", MB + 32'h08, 32'h0);
    wr(MB + 32'h14, 32'h2);
    wr(MB + 32'h08, 32'd9);
    wr(MB + 32'h0C, 32'd10);
    wr(MB + 32'h10, 32'h1);
    wr(MB + 32'h14, 32'h3);
    check("irq_idle", 32'(timer_irq), 32'h0);
    wr(MB + 32'h10, 32'h1);
    check("irq_set_wins", 32'(timer_irq), 32'h1);
    check_rd("status_set_wins", MB + 32'h10, 32'h1);
    check_rd("cnt10", MB + 32'h08, 32'd10);
`else
    for (int o = 2; o <= 5; o++) wr(MB + 32'(o * 4), 32'hFFFF_FFFF);
    for (int o = 2; o <= 5; o++) check_rd($sformatf("notimer_off%0d", o * 4), MB + 32'(o * 4), 32'h0);
    check("notimer_irq", 32'(timer_irq), 32'h0);
`endif

    // Asynchronous reset mid-operation; a store held across the reset is dropped
    drv(32'h20, 32'hBAD0_BAD0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_irq", 32'(timer_irq), 32'h0);
    check("arst_gpio", 32'(gpio_out), 32'h0);
    check_rd("arst_cnt", MB + 32'h08, 32'h0);
    check_rd("arst_cmp", MB + 32'h0C, CMP_RST);
    check_rd("arst_status", MB + 32'h10, 32'h0);
    check_rd("arst_gin", MB + 32'h04, 32'h0);
    drv(32'h20, 32'hBAD0_BAD0, 1'b1);
    tick();
    tick();
    mem_write = 1'b0;
    reset = 1'b1;
    check_rd("store_dropped", 32'h20, 32'h0000_600D);

    // Randomized traffic against the model, from a fresh reset
    gpio_in = 8'h0;
    reset = 1'b0;
    #2 reset = 1'b1;
    m_reset();
    for (int i = 0; i < RW; i++) m_val[i] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 9));
      ro   = 4'($urandom_range(0, 15));
      if (kind < 3)       ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (kind == 3) ra = 32'h0000_0400 + 32'($urandom_range(0, 4095) * 4);
      else if (kind < 7)  ra = MB + {26'h0, ro, 2'b00};
      else                ra = MB + 32'($urandom_range(2, 5) * 4);
      rw = ($urandom_range(0, 2) == 0);
      if (ra[31:6] == MB[31:6] && (ra[5:2] == 4'h2 || ra[5:2] == 4'h3))
        rd_v = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                           : 32'($urandom_range(0, 40));
      else
        rd_v = $urandom;
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      drv(ra, rd_v, rw);
      #1;
      r = m_read(ra);
      if (r[32]) check($sformatf("rand%0d_rd@%h", i, ra), read_data, r[31:0]);
      check($sformatf("rand%0d_gpio", i), 32'(gpio_out), 32'(m_gpio));
      check($sformatf("rand%0d_irq", i), 32'(timer_irq), 32'(TIMER & m_match & m_ien));
      m_edge(ra, rd_v, rw, gpio_in);
      tick();
    end
    mem_write = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
